dmem_bus_bridge: RTL and testbench

- Sits directly downstream of the data-memory lane/shift controller.
- Takes its aligned word address, write data and byte strobes and converts the single-cycle memory interface into a registered valid/ready request/response bus.
- Stalls the core until the response returns, then returns read data (unshifted word) and an error flag to the controller.

---
 rtl/dmem_bus_bridge.sv | 130 +++++++++++++
 tb/tb_dmem_bus_bridge.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_bridge.sv
// Converts the single-cycle data-memory interface into a registered valid/ready request/response bus.
// Optional abort-on-timeout is enabled by defining DMEM_BUS_BRIDGE_TIMEOUT_EN.
module dmem_bus_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        core_req,
   input  logic        core_we,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_wdata,
   input  logic [3:0]  core_wstrb,
   output logic [31:0] core_rdata,
   output logic        core_err,
   output logic        stall,
   output logic        bus_req_valid,
   input  logic        bus_req_ready,
   output logic [31:0] bus_addr,
   output logic        bus_we,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic        bus_resp_valid,
   output logic        bus_resp_ready,
   input  logic [31:0] bus_resp_rdata,
   input  logic        bus_resp_err
);

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

   state_t state;
   logic   timeout_c;
   logic   unused_addr_lsb;

   // The address is word-aligned; the low bits never reach the bus.
   assign unused_addr_lsb = ^core_addr[1:0];

   // Marks an invalid configuration: the counter could never reach TIMEOUT_CYCLES.
   if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_cnt_w_too_small
      logic unused_cfg_error;
      assign unused_cfg_error = 1'b1;
   end

`ifdef DMEM_BUS_BRIDGE_TIMEOUT_EN
   logic [CNT_W-1:0] wait_cnt;

   // Counts bus wait cycles; zero on the first REQ cycle of every transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (state == IDLE) begin
         wait_cnt <= '0;
      end else if (state == REQ || state == RESP) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end

   assign timeout_c = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_c = 1'b0;
`endif

   // DONE is the single cycle in which the core sees its result and advances.
   assign stall = core_req & (state != DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         bus_req_valid  <= 1'b0;
         bus_resp_ready <= 1'b0;
         bus_addr       <= '0;
         bus_we         <= 1'b0;
         bus_wdata      <= '0;
         bus_wstrb      <= '0;
         core_rdata     <= '0;
         core_err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (core_req) begin
                  state         <= REQ;
                  bus_req_valid <= 1'b1;
                  bus_addr      <= {core_addr[31:2], 2'b00};
                  bus_we        <= core_we;
                  bus_wdata     <= core_wdata;
                  bus_wstrb     <= core_we ? core_wstrb : 4'b0000;
                  core_err      <= 1'b0;
               end
            end
            REQ: begin
               if (timeout_c) begin
                  state         <= DONE;
                  bus_req_valid <= 1'b0;
                  core_err      <= 1'b1;
                  core_rdata    <= '0;
               end else if (bus_req_valid && bus_req_ready) begin
                  state          <= RESP;
                  bus_req_valid  <= 1'b0;
                  bus_resp_ready <= 1'b1;
               end
            end
            RESP: begin
               if (bus_resp_valid) begin
                  state          <= DONE;
                  bus_resp_ready <= 1'b0;
                  core_err       <= bus_resp_err;
                  if (!bus_we) begin
                     core_rdata <= bus_resp_rdata;
                  end
               end else if (timeout_c) begin
                  state          <= DONE;
                  bus_resp_ready <= 1'b0;
                  core_err       <= 1'b1;
                  core_rdata     <= '0;
               end
            end
            DONE: begin
               // The request still held high here was just served.
               state <= IDLE;
            end
            default: begin
               state          <= IDLE;
               bus_req_valid  <= 1'b0;
               bus_resp_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Self-checking bench for dmem_bus_bridge: directed vector table, hand sequences and
// randomized transactions against a transaction-level reference model.
module tb_dmem_bus_bridge;

`ifdef DMEM_BUS_BRIDGE_TIMEOUT_EN
   localparam int unsigned TO = 8;
`else
   localparam int unsigned TO = 255;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        core_req, core_we;
   logic [31:0] core_addr, core_wdata;
   logic [3:0]  core_wstrb;
   logic [31:0] core_rdata;
   logic        core_err, stall;
   logic        bus_req_valid, bus_req_ready;
   logic [31:0] bus_addr;
   logic        bus_we;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_resp_valid, bus_resp_ready;
   logic [31:0] bus_resp_rdata;
   logic        bus_resp_err;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] model_rdata = 32'h0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          req_delay;
      int          resp_delay;
      logic [31:0] rdata;
      logic        err;
      int          exp_stall;
      logic [31:0] exp_addr;
      logic [3:0]  exp_wstrb;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   dmem_bus_bridge #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .core_req       (core_req),
      .core_we        (core_we),
      .core_addr      (core_addr),
      .core_wdata     (core_wdata),
      .core_wstrb     (core_wstrb),
      .core_rdata     (core_rdata),
      .core_err       (core_err),
      .stall          (stall),
      .bus_req_valid  (bus_req_valid),
      .bus_req_ready  (bus_req_ready),
      .bus_addr       (bus_addr),
      .bus_we         (bus_we),
      .bus_wdata      (bus_wdata),
      .bus_wstrb      (bus_wstrb),
      .bus_resp_valid (bus_resp_valid),
      .bus_resp_ready (bus_resp_ready),
      .bus_resp_rdata (bus_resp_rdata),
      .bus_resp_err   (bus_resp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input int rqd, input int rsd,
                               input logic [31:0] rdata, input logic err, input int exp_stall,
                               input logic [31:0] exp_addr, input logic [3:0] exp_wstrb,
                               input logic [31:0] exp_rdata, input logic exp_err);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
      v.req_delay = rqd; v.resp_delay = rsd; v.rdata = rdata; v.err = err;
      v.exp_stall = exp_stall; v.exp_addr = exp_addr; v.exp_wstrb = exp_wstrb;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err;
      return v;
   endfunction

   task automatic chk_reset(input string tag);
      check({tag, ".bus_req_valid"},  32'(bus_req_valid),  32'h0);
      check({tag, ".bus_resp_ready"}, 32'(bus_resp_ready), 32'h0);
      check({tag, ".bus_we"},         32'(bus_we),         32'h0);
      check({tag, ".bus_addr"},       bus_addr,            32'h0);
      check({tag, ".bus_wdata"},      bus_wdata,           32'h0);
      check({tag, ".bus_wstrb"},      32'(bus_wstrb),      32'h0);
      check({tag, ".core_rdata"},     core_rdata,          32'h0);
      check({tag, ".core_err"},       32'(core_err),       32'h0);
      check({tag, ".stall"},          32'(stall),          32'h0);
   endtask

   // Entered and left at posedge+1; responder follows the vector's delays.
   task automatic run_txn(input vec_t v, input bit keep_req, input string tag);
      int  stall_cnt = 0;
      int  hs = 0;
      int  valid_seen = 0;
      int  ready_seen = 0;
      int  cyc = 0;
      bit  done = 1'b0;
      core_req   = 1'b1;
      core_we    = v.we;
      core_addr  = v.addr;
      core_wdata = v.wdata;
      core_wstrb = v.wstrb;
      while (!done && cyc < 100) begin
         bus_req_ready  = bus_req_valid && (valid_seen >= v.req_delay);
         bus_resp_valid = bus_resp_ready && (ready_seen >= v.resp_delay);
         bus_resp_rdata = bus_resp_valid ? v.rdata : $urandom;
         bus_resp_err   = bus_resp_valid ? v.err : 1'b0;
         #1;
         if (cyc == 0) check({tag, ".no_req_in_idle"}, 32'(bus_req_valid), 32'h0);
         if (cyc == 1) check({tag, ".err_cleared"}, 32'(core_err), 32'h0);
         if (cyc >= 1) begin
            // The bridge must hold its own copy of the request fields.
            core_addr  = $urandom;
            core_wdata = $urandom;
            core_wstrb = 4'($urandom);
         end
         if (bus_req_valid) begin
            check({tag, ".bus_addr"},  bus_addr,        v.exp_addr);
            check({tag, ".bus_we"},    32'(bus_we),     32'(v.we));
            check({tag, ".bus_wdata"}, bus_wdata,       v.wdata);
            check({tag, ".bus_wstrb"}, 32'(bus_wstrb),  32'(v.exp_wstrb));
            valid_seen++;
            if (bus_req_ready) hs++;
         end
         if (bus_resp_ready) ready_seen++;
         if (stall) begin
            stall_cnt++;
         end else begin
            check({tag, ".core_rdata"}, core_rdata,    v.exp_rdata);
            check({tag, ".core_err"},   32'(core_err), 32'(v.exp_err));
            done = 1'b1;
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL %s.timeout: no DONE within %0d cycles", tag, cyc);
      end
      check({tag, ".stall_cycles"}, 32'(stall_cnt), 32'(v.exp_stall));
      check({tag, ".handshakes"},   32'(hs),        32'h1);
      bus_req_ready  = 1'b0;
      bus_resp_valid = 1'b0;
      if (!keep_req) core_req = 1'b0;
   endtask

   task automatic idle(input int n, input string tag);
      core_req = 1'b0;
      for (int i = 0; i < n; i++) begin
         #1;
         check({tag, ".idle_stall"}, 32'(stall),         32'h0);
         check({tag, ".idle_valid"}, 32'(bus_req_valid), 32'h0);
         @(posedge clk); #1;
      end
   endtask

   vec_t tbl[5];

   initial begin
      rst_n = 1'b0;
      core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0; core_wstrb = '0;
      bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_rdata = '0; bus_resp_err = 1'b0;

      //           we    addr           wdata          strb  rqd rsd rdata          err  stl exp_addr       exp_strb exp_rdata     exp_err
      tbl[0] = mk(1'b0, 32'h0000_1006, 32'h0,         4'h0, 0,  0,  32'hDEAD_BEEF, 1'b0, 3, 32'h0000_1004, 4'h0, 32'hDEAD_BEEF, 1'b0);
      tbl[1] = mk(1'b1, 32'h0000_0020, 32'h1122_3344, 4'hC, 5,  0,  32'hFFFF_0000, 1'b0, 8, 32'h0000_0020, 4'hC, 32'hDEAD_BEEF, 1'b0);
      tbl[2] = mk(1'b0, 32'h0000_0003, 32'h0BAD_0BAD, 4'h0, 1,  2,  32'h1234_5678, 1'b1, 6, 32'h0000_0000, 4'h0, 32'h1234_5678, 1'b1);
      tbl[3] = mk(1'b1, 32'hFFFF_FFFF, 32'hCAFE_F00D, 4'h0, 0,  3,  32'h7777_7777, 1'b0, 6, 32'hFFFF_FFFC, 4'h0, 32'h1234_5678, 1'b0);
      tbl[4] = mk(1'b0, 32'h8000_0001, 32'h5555_AAAA, 4'hF, 2,  0,  32'hA5A5_5A5A, 1'b0, 5, 32'h8000_0000, 4'h0, 32'hA5A5_5A5A, 1'b0);

      repeat (2) @(posedge clk);
      #1;
      chk_reset("reset");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk_reset("after_release");

      for (int i = 0; i < 5; i++) begin
         run_txn(tbl[i], 1'b0, $sformatf("vec%0d", i));
         idle(1, $sformatf("vec%0d", i));
      end

      // Back-to-back loads with core_req held high throughout.
      run_txn(mk(1'b0, 32'h200, 32'h0, 4'h0, 0, 0, 32'h0101_0101, 1'b0, 3, 32'h200, 4'h0, 32'h0101_0101, 1'b0), 1'b1, "b2b0");
      run_txn(mk(1'b0, 32'h204, 32'h0, 4'h0, 0, 1, 32'h0202_0202, 1'b0, 4, 32'h204, 4'h0, 32'h0202_0202, 1'b0), 1'b0, "b2b1");
      idle(3, "b2b");

      // Asynchronous reset while waiting for a response.
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40; core_wdata = 32'h0; core_wstrb = 4'h0;
      bus_req_ready = 1'b1;
      for (int i = 0; i < 10 && !bus_resp_ready; i++) begin
         @(posedge clk); #1;
      end
      check("rst_mid.in_resp", 32'(bus_resp_ready), 32'h1);
      bus_req_ready = 1'b0;
      core_req = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk_reset("rst_mid");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk_reset("rst_mid_release");
      run_txn(mk(1'b0, 32'h44, 32'h0, 4'h0, 0, 0, 32'h3C3C_C3C3, 1'b0, 3, 32'h44, 4'h0, 32'h3C3C_C3C3, 1'b0), 1'b0, "post_rst");
      model_rdata = 32'h3C3C_C3C3;

      // Random transactions checked against the transaction-level model.
      for (int i = 0; i < 40; i++) begin
         vec_t v;
         bit   keep;
         v.we = 1'($urandom_range(0, 1));
         v.addr = $urandom;
         v.wdata = $urandom;
         v.wstrb = 4'($urandom);
         v.req_delay = $urandom_range(0, 2);
         v.resp_delay = $urandom_range(0, 2);
         v.rdata = $urandom;
         v.err = ($urandom_range(0, 3) == 0);
         v.exp_stall = 3 + v.req_delay + v.resp_delay;
         v.exp_addr = v.addr & 32'hFFFF_FFFC;
         v.exp_wstrb = v.we ? v.wstrb : 4'h0;
         v.exp_rdata = v.we ? model_rdata : v.rdata;
         v.exp_err = v.err;
         model_rdata = v.exp_rdata;
         keep = 1'($urandom_range(0, 1));
         run_txn(v, keep, $sformatf("rnd%0d", i));
         if (!keep) idle($urandom_range(0, 2), $sformatf("rnd%0d", i));
      end
      idle(1, "rnd_end");

`ifdef DMEM_BUS_BRIDGE_TIMEOUT_EN
      begin
         int stall_cnt = 0;
         int vseen = 0;
         bit done = 1'b0;
         core_req = 1'b1; core_we = 1'b0; core_addr = 32'h100; core_wdata = '0; core_wstrb = '0;
         for (int i = 0; i < 50 && !done; i++) begin
            bus_req_ready = bus_req_valid && (vseen >= 2);
            bus_resp_valid = 1'b0;
            #1;
            if (bus_req_valid) vseen++;
            if (stall) stall_cnt++;
            else done = 1'b1;
            if (!done) begin
               @(posedge clk); #1;
            end
         end
         check("to.done_reached", 32'(done), 32'h1);
         check("to.stall_cycles", 32'(stall_cnt), 32'(1 + TO));
         check("to.core_err", 32'(core_err), 32'h1);
         check("to.core_rdata", core_rdata, 32'h0);
         check("to.bus_req_valid", 32'(bus_req_valid), 32'h0);
         @(posedge clk); #1;
         core_req = 1'b0;
         bus_req_ready = 1'b0;
         bus_resp_valid = 1'b1; bus_resp_rdata = 32'h5555_5555; bus_resp_err = 1'b0;
         for (int i = 0; i < 3; i++) begin
            #1;
            check("to.late_resp_ready", 32'(bus_resp_ready), 32'h0);
            check("to.late_rdata", core_rdata, 32'h0);
            check("to.late_err", 32'(core_err), 32'h1);
            @(posedge clk); #1;
         end
         bus_resp_valid = 1'b0;
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
